// File: rtl/timer_irq_dev.sv
`default_nettype none
// ============================================================================
// Module   : timer_irq_dev
// Purpose  : Memory-mapped countdown timer that drives one HWInt line into
//            the CP0 interrupt logic. Supports one-shot mode (level irq held
//            until software acks) and periodic mode (one-cycle irq pulse,
//            auto-reload).
// Ports    : clk    - system clock, all state on posedge
//            reset  - synchronous reset, active-low
//            addr   - word select: 0=CTRL, 1=PRESET, 2=COUNT (RO), 3=reserved
//            we     - write strobe
//            wdata  - write data
//            rdata  - combinational read data for addr
//            irq    - interrupt request (pending & CTRL.IM)
// Revision : 1.0 - initial release
// ============================================================================
module timer_irq_dev #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_PERIOD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_pending;

    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_periodic;
    logic             w_load;
    logic             w_dec;
    logic             w_expire;
    logic             w_hw_clr_en;
    logic             w_pend_clr;

    assign w_wr_ctrl   = we && (addr == c_ADDR_CTRL);
    assign w_wr_preset = we && (addr == c_ADDR_PRESET);
    // Modes 10/11 fall back to one-shot behaviour.
    assign w_periodic  = (r_mode == c_MODE_PERIOD);

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // IDLE looks at the stored EN, so an enabling write first lands in CTRL
    // and the FSM leaves IDLE one edge later; expiry follows N+2 edges after
    // the enabling write.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_expire    = 1'b0;
        w_hw_clr_en = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_dec = 1'b1;
                end else begin
                    // COUNT of 0 or 1 both end the count; no wrap below zero.
                    w_expire    = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_periodic) begin
                    w_pend_clr  = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_hw_clr_en = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'b00;
            r_im      <= 1'b0;
            r_preset  <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // A software CTRL write overrides the hardware EN clear.
            if (w_wr_ctrl) begin
                r_en   <= wdata[0];
                r_mode <= wdata[2:1];
                r_im   <= wdata[3];
            end else if (w_hw_clr_en) begin
                r_en <= 1'b0;
            end

            // PRESET only reaches COUNT in LOAD, so a mid-count write is
            // picked up at the next reload.
            if (w_wr_preset) begin
                r_preset <= CNT_W'(wdata);
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - CNT_W'(1);
            end else if (w_expire) begin
                r_count <= '0;
            end

            // An expiry on the same edge as an ack is kept, not lost.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (w_pend_clr || w_wr_ctrl || w_wr_preset) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        case (addr)
            c_ADDR_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
            c_ADDR_PRESET: rdata = 32'(r_preset);
            c_ADDR_COUNT:  rdata = 32'(r_count);
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = r_pending & r_im;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_dev.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_irq_dev
// Purpose  : Directed self-checking bench for timer_irq_dev. Edge E0 is the
//            edge that samples the enabling CTRL write; with PRESET=N the irq
//            is first visible after E0+N+2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_irq_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_pass;
    int n_tot;

    timer_irq_dev #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;

        // 1. Reset held with writes attempted.
        reset = 1'b0; we = 1'b1; addr = 2'd0; wdata = 32'hF;
        step();
        addr = 2'd1;
        step();
        chk("rst_irq", 32'(irq), 32'd0);
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count", 2'd2, 32'd0);
        we = 1'b0; reset = 1'b1;
        step();
        chk_rd("rst_ctrl_after", 2'd0, 32'd0);

        // 2. One-shot, PRESET=5, IM=1.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                       // E0
        chk("os_irq_e0", 32'(irq), 32'd0);
        step();                                // E0+1 LOAD
        chk_rd("os_cnt_e1", 2'd2, 32'd0);
        step(); chk_rd("os_cnt_5", 2'd2, 32'd5);
        step(); chk_rd("os_cnt_4", 2'd2, 32'd4);
        step(); chk_rd("os_cnt_3", 2'd2, 32'd3);
        step(); chk_rd("os_cnt_2", 2'd2, 32'd2);
        step(); chk_rd("os_cnt_1", 2'd2, 32'd1);
        chk("os_irq_e6", 32'(irq), 32'd0);
        step(); chk_rd("os_cnt_0", 2'd2, 32'd0); // E0+7
        chk("os_irq_e7", 32'(irq), 32'd1);
        step();
        chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
        chk("os_irq_e8", 32'(irq), 32'd1);
        step();
        chk("os_irq_held", 32'(irq), 32'd1);
        wr(2'd0, 32'h0);
        chk("os_irq_ack", 32'(irq), 32'd0);

        // 3. Periodic, PRESET=3: pulses at E0+5, +10, +15, +20.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                       // E0
        for (int k = 1; k <= 22; k++) begin
            step();
            chk($sformatf("per_irq_k%0d", k), 32'(irq), (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        chk_rd("per_cnt_e22", 2'd2, 32'd3);
        wr(2'd0, 32'h0);                       // E0+23, last decrement to 2
        for (int k = 0; k < 10; k++) begin
            step();
            chk("per_off_irq", 32'(irq), 32'd0);
        end
        chk_rd("per_cnt_frozen", 2'd2, 32'd2);

        // 4a. PRESET=0 one-shot: irq after E0+3.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(); step();
        chk("p0_irq_e2", 32'(irq), 32'd0);
        step();
        chk("p0_irq_e3", 32'(irq), 32'd1);
        wr(2'd0, 32'h0);
        chk("p0_irq_ack", 32'(irq), 32'd0);

        // 4b. PRESET=1 one-shot: irq after E0+3; re-enable on the INT edge.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);                       // E0
        step(); step();
        chk("p1_irq_e2", 32'(irq), 32'd0);
        step();
        chk("p1_irq_e3", 32'(irq), 32'd1);
        wr(2'd0, 32'h9);                       // E0+4: SW EN beats HW clear
        chk("p1_irq_ack", 32'(irq), 32'd0);
        chk_rd("p1_ctrl_sw_wins", 2'd0, 32'h9);
        step(); step();                        // E0+6 CNT
        chk("p1_irq_e6", 32'(irq), 32'd0);
        step();
        chk("p1_irq_e7", 32'(irq), 32'd1);
        wr(2'd0, 32'h0);
        chk("p1_irq_ack2", 32'(irq), 32'd0);

        // 4c. PRESET=4, PRESET=9 written mid-count: expiry stays at E0+6.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);                       // E0
        step(); step();                        // E0+2 COUNT=4
        wr(2'd1, 32'd9);                       // E0+3
        chk_rd("mid_cnt_3", 2'd2, 32'd3);
        step(); step();                        // E0+5
        chk("mid_irq_e5", 32'(irq), 32'd0);
        step();
        chk("mid_irq_e6", 32'(irq), 32'd1);
        chk_rd("mid_preset", 2'd1, 32'd9);
        wr(2'd0, 32'h0);
        chk("mid_irq_ack", 32'(irq), 32'd0);

        // 5. One-shot with IM=0, then IM set by a CTRL write (which acks).
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);                       // E0, expiry at E0+4
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("im0_irq", 32'(irq), 32'd0);
        end
        chk_rd("im0_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk("im_set_irq", 32'(irq), 32'd0);
        step();
        chk("im_set_irq2", 32'(irq), 32'd0);

        // 6. Reset mid-count with COUNT=7.
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h9);                       // E0
        step(); step();
        chk_rd("rc_cnt_7", 2'd2, 32'd7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_rd("rc_cnt_0", 2'd2, 32'd0);
        chk_rd("rc_ctrl_0", 2'd0, 32'd0);
        chk_rd("rc_preset_0", 2'd1, 32'd0);
        chk("rc_irq", 32'(irq), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
        end
        chk_rd("rc_idle_cnt", 2'd2, 32'd0);
        chk("rc_idle_irq", 32'(irq), 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);                       // E1, expiry at E1+4
        step(); step();
        chk_rd("rc_resume_cnt", 2'd2, 32'd2);
        step();
        chk("rc_resume_e3", 32'(irq), 32'd0);
        step();
        chk("rc_resume_e4", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
